// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit state encoding.
package uart_tx_pkg;

    // Word offsets within the 16-byte window (bus_addr[3:2]).
    localparam logic [1:0] TXDATA  = 2'd0;
    localparam logic [1:0] STATUS  = 2'd1;
    localparam logic [1:0] BAUDDIV = 2'd2;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter; pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module tx_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [WIDTH-1:0]              i_din,
    output logic [WIDTH-1:0]              o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Handshake: push is accepted only while !full, pop only while !empty;
    // a request that is not accepted has no effect, and both may fire on one edge.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Console transmitter on the data-memory port: window decode, TXDATA/STATUS/BAUDDIV
// registers, baud-period counter and the 8N1 transmit state machine.
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_wdata,
    input  logic [3:0]  i_bus_we,
    input  logic        i_bus_re,
    output logic [31:0] o_bus_rdata,
    output logic        o_tx,
    output logic [1:0]  o_dbg_state
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic            w_sel;
    logic [1:0]      w_off;
    logic            w_push;
    logic            w_ovf_clr;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [7:0]      w_fifo_dout;
    logic [LW-1:0]   w_fifo_level;
    logic [3:0]      w_level4;
    logic [15:0]     w_div_eff;
    logic            w_bit_end;
    logic [31:0]     w_status;
    logic            w_unused_ok;

    tx_state_t       r_state;
    tx_state_t       w_state_nx;
    logic            r_ovf;
    logic [15:0]     r_baud_div;
    logic [15:0]     r_baud_cnt;
    logic [15:0]     w_cnt_nx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nx;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nx;
    logic            r_tx;
    logic            w_tx_nx;

    assign w_sel       = (i_bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off       = i_bus_addr[3:2];
    assign w_push      = w_sel && (w_off == TXDATA) && i_bus_we[0];
    assign w_ovf_clr   = w_sel && (w_off == STATUS) && i_bus_we[0] && i_bus_wdata[ST_OVF];
    assign w_unused_ok = ^{i_bus_addr[1:0], i_bus_wdata[31:16], i_bus_we[3:2]};

    tx_fifo #(
        .WIDTH      (8),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (i_bus_wdata[7:0]),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf      <= 1'b0;
            r_baud_div <= DEFAULT_DIV;
        end else begin
            // Full is the pre-edge state, so a same-edge pop does not rescue the byte.
            if (w_push && w_fifo_full) r_ovf <= 1'b1;
            else if (w_ovf_clr)        r_ovf <= 1'b0;
            if (w_sel && (w_off == BAUDDIV)) begin
                if (i_bus_we[0]) r_baud_div[7:0]  <= i_bus_wdata[7:0];
                if (i_bus_we[1]) r_baud_div[15:8] <= i_bus_wdata[15:8];
            end
        end
    end

    assign w_div_eff = (r_baud_div == 16'd0) ? 16'd1 : r_baud_div;
    assign w_bit_end = (r_baud_cnt == 16'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_cnt_nx;
            r_shift    <= w_shift_nx;
            r_bit_idx  <= w_bit_idx_nx;
            r_tx       <= w_tx_nx;
        end
    end

    // Each bit start reloads the counter, so a divisor change lands on the next bit.
    always_comb begin
        w_state_nx   = r_state;
        w_pop        = 1'b0;
        w_tx_nx      = r_tx;
        w_shift_nx   = r_shift;
        w_bit_idx_nx = r_bit_idx;
        w_cnt_nx     = r_baud_cnt;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_START;
                    w_shift_nx = w_fifo_dout;
                    w_tx_nx    = 1'b0;
                    w_cnt_nx   = w_div_eff;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx   = S_DATA;
                    w_tx_nx      = r_shift[0];
                    w_bit_idx_nx = 3'd0;
                    w_cnt_nx     = w_div_eff;
                end else begin
                    w_cnt_nx = r_baud_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = w_div_eff;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_tx_nx      = r_shift[1];
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_baud_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_pop      = 1'b1;
                        w_state_nx = S_START;
                        w_shift_nx = w_fifo_dout;
                        w_tx_nx    = 1'b0;
                        w_cnt_nx   = w_div_eff;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = 16'd0;
                    end
                end else begin
                    w_cnt_nx = r_baud_cnt - 16'd1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_level4 = 4'(w_fifo_level);

    always_comb begin
        w_status                        = '0;
        w_status[ST_FULL]               = w_fifo_full;
        w_status[ST_EMPTY]              = w_fifo_empty;
        w_status[ST_BUSY]               = (r_state != S_IDLE);
        w_status[ST_OVF]                = r_ovf;
        w_status[ST_LEVEL_LSB +: 4]     = w_level4;
    end

    always_comb begin
        o_bus_rdata = '0;
        if (i_rst_n && w_sel && i_bus_re) begin
            case (w_off)
                STATUS:  o_bus_rdata = w_status;
                BAUDDIV: o_bus_rdata = {16'd0, r_baud_div};
                default: o_bus_rdata = '0;
            endcase
        end
    end

    assign o_tx        = r_tx;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register reads checked inline, serial frames
// checked by a tx-line monitor against a queue of expected bytes and bit lengths.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] A_TXD  = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        tx;
    logic [1:0]  dbg_state;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    logic [7:0]  exp_q[$];
    int unsigned exp_div_q[$];
    bit          exp_contig_q[$];

    uart_tx_mmio dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bus_addr  (addr),
        .i_bus_wdata (wdata),
        .i_bus_we    (we),
        .i_bus_re    (re),
        .o_bus_rdata (rdata),
        .o_tx        (tx),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- driver tasks (called just after a negedge) ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        addr  = a;
        wdata = d;
        we    = w;
        @(negedge clk);
        we    = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b1;
        #1;
        d    = rdata;
        re   = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_write(A_TXD, {24'd0, b}, 4'b0001);
    endtask

    // Bits 0..9 = start, data0..data7, stop; bits from sw_bit onward use div_b.
    task automatic expect_frame(input logic [7:0] b, input int unsigned div_a,
                                input int unsigned div_b, input int sw_bit, input bit contig);
        exp_q.push_back(b);
        for (int k = 0; k < 10; k++) exp_div_q.push_back((k < sw_bit) ? div_a : div_b);
        exp_contig_q.push_back(contig);
    endtask

    task automatic wait_idle(input int max_cyc);
        logic [31:0] s;
        int n;
        n = 0;
        bus_read(A_STAT, s);
        while (s[2] && n < max_cyc) begin
            bus_read(A_STAT, s);
            n++;
        end
        check("idle_reached_busy", {31'd0, s[2]}, 32'd0);
    endtask

    task automatic reset_mid_frame_check();
        #3;
        check("tx_low_before_reset", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("tx_async_high_in_reset", {31'd0, tx}, 32'd1);
        addr = A_STAT;
        re   = 1'b1;
        #1;
        check("rdata_zero_in_reset", rdata, 32'd0);
        re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("status_after_reset", A_STAT, 32'h0000_0002);
        read_check("bauddiv_after_reset", A_DIV, 32'd434);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int unsigned cyc;
        int unsigned last_end;
        int unsigned cnt;
        int unsigned bad;
        int          bitk;
        int unsigned divs[10];
        logic [7:0]  d;
        logic        expb;
        bit          active;
        bit          stray;
        bit          contig;
        cyc = 0; last_end = 0; cnt = 0; bad = 0; bitk = 0;
        d = '0; active = 0; stray = 0; contig = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                active = 0;
                stray  = 0;
                continue;
            end
            if (stray && tx === 1'b1) stray = 0;
            if (!active && !stray && tx === 1'b0) begin
                check("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() == 0) begin
                    stray = 1;
                end else begin
                    d      = exp_q.pop_front();
                    contig = exp_contig_q.pop_front();
                    for (int k = 0; k < 10; k++) divs[k] = exp_div_q.pop_front();
                    if (contig) check($sformatf("frame_%02h_no_gap_cycle", d), cyc, last_end + 1);
                    active = 1;
                    bitk   = 0;
                    cnt    = 0;
                    bad    = 0;
                end
            end
            if (active) begin
                expb = (bitk == 0) ? 1'b0 : (bitk == 9) ? 1'b1 : d[bitk-1];
                if (tx !== expb) bad++;
                cnt++;
                if (cnt == divs[bitk]) begin
                    check($sformatf("frame_%02h_bit%0d_bad_samples", d, bitk), bad, 32'd0);
                    bitk++;
                    cnt = 0;
                    bad = 0;
                    if (bitk == 10) begin
                        active   = 0;
                        last_end = cyc;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [31:0] s;
        int          cnt;
        int          n;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("tx_idle_after_reset", {31'd0, tx}, 32'd1);
        read_check("status_reset", A_STAT, 32'h0000_0002);
        read_check("bauddiv_reset", A_DIV, 32'h0000_01B2);
        read_check("txdata_reads_zero", A_TXD, 32'd0);

        // Register access
        bus_write(A_DIV, 32'h0000_1234, 4'b0001);
        read_check("bauddiv_lane0_only", A_DIV, 32'h0000_0134);
        bus_write(A_DIV, 32'h0000_5600, 4'b0010);
        read_check("bauddiv_lane1_only", A_DIV, 32'h0000_5634);
        bus_write(A_DIV, 32'hFFFF_FFFF, 4'b1100);
        read_check("bauddiv_upper_lanes_ignored", A_DIV, 32'h0000_5634);
        read_check("bauddiv_low_addr_bits_ignored", BASE + 32'hA, 32'h0000_5634);
        bus_write(A_RSV, 32'hFFFF_FFFF, 4'b1111);
        read_check("reserved_reads_zero", A_RSV, 32'd0);
        read_check("unselected_reads_zero", BASE + 32'h18, 32'd0);
        read_check("unselected_high_reads_zero", BASE ^ 32'h1000_0008, 32'd0);
        addr = A_DIV;
        re   = 1'b0;
        #1;
        check("no_re_reads_zero", rdata, 32'd0);
        @(negedge clk);
        bus_write(A_TXD, 32'h0000_00AA, 4'b1110);
        read_check("txdata_without_lane0_no_push", A_STAT, 32'h0000_0002);

        // Single byte 0xA5, div 4
        bus_write(A_DIV, 32'h0000_0004, 4'b0011);
        expect_frame(8'hA5, 4, 4, 10, 0);
        push_byte(8'hA5);
        bus_read(A_STAT, s);
        check("status_cycle_after_push", s, 32'h0000_0100);
        n = 0;
        bus_read(A_STAT, s);
        while (!s[2] && n < 8) begin
            bus_read(A_STAT, s);
            n++;
        end
        cnt = 0;
        while (s[2] && cnt < 1000) begin
            cnt++;
            bus_read(A_STAT, s);
        end
        check("busy_clocks_single_byte", cnt, 32'd40);
        check("status_after_single_byte", s, 32'h0000_0002);

        // Back-to-back frames, div 2
        bus_write(A_DIV, 32'h0000_0002, 4'b0011);
        expect_frame(8'h00, 2, 2, 10, 0);
        expect_frame(8'hFF, 2, 2, 10, 1);
        expect_frame(8'h55, 2, 2, 10, 1);
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        wait_idle(200);
        read_check("status_after_back_to_back", A_STAT, 32'h0000_0002);

        // Divisor 4 -> 8 during data bit 3
        bus_write(A_DIV, 32'h0000_0004, 4'b0011);
        expect_frame(8'h3C, 4, 8, 5, 0);
        push_byte(8'h3C);
        repeat (17) @(negedge clk);
        bus_write(A_DIV, 32'h0000_0008, 4'b0011);
        wait_idle(300);

        // Overflow with the transmitter stalled
        bus_write(A_DIV, 32'h0000_FFFF, 4'b0011);
        expect_frame(8'h11, 32'hFFFF, 32'hFFFF, 10, 0);
        push_byte(8'h11);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) push_byte(8'h20 + 8'(i));
        read_check("status_overflow_full", A_STAT, 32'h0000_080D);
        bus_write(A_STAT, 32'h0000_0000, 4'b0001);
        read_check("status_write_bit3_zero_keeps_ovf", A_STAT, 32'h0000_080D);
        bus_write(A_STAT, 32'h0000_0008, 4'b0001);
        read_check("status_overflow_cleared", A_STAT, 32'h0000_0805);
        reset_mid_frame_check();

        // Reset in the middle of a data bit
        bus_write(A_DIV, 32'h0000_0004, 4'b0011);
        expect_frame(8'h5A, 4, 4, 10, 0);
        push_byte(8'h5A);
        repeat (14) @(negedge clk);
        reset_mid_frame_check();
        repeat (4) @(negedge clk);
        check("tx_idle_at_end", {31'd0, tx}, 32'd1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
